// File: rtl/bgr_startup_ctrl_pkg.sv
// Shared definitions for the bandgap startup sequencer: FSM state encoding,
// register word offsets, CTRL/STATUS bit positions and the STATUS word packer.
package bgr_startup_ctrl_pkg;

  // Encoding is visible on state_o and in STATUS[2:0], so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PORST  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_FAIL   = 3'd5
  } bgr_state_e;

  // Word offsets (wbs_adr_i[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_PORST  = 2'd2;
  localparam logic [1:0] OFF_SETTLE = 2'd3;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  // STATUS bits above the 3-bit state field
  localparam int STAT_READY = 3;
  localparam int STAT_DONE  = 4;
  localparam int STAT_FAIL  = 5;
  localparam int STAT_LOST  = 6;

  function automatic logic [31:0] status_word(input logic [2:0] st, input logic ready,
                                              input logic done, input logic fail,
                                              input logic lost);
    return {25'd0, lost, fail, done, ready, st};
  endfunction

endpackage

// File: rtl/bgr_startup_ctrl_if.sv
// Wishbone slave bus bundle for bgr_startup_ctrl. Signal suffixes are from the
// slave's point of view.
//  cyc_i/stb_i/we_i : cycle, strobe, write enable
//  sel_i            : byte selects (accepted, not used; all accesses are full-word)
//  adr_i/dat_i      : byte address, write data
//  ack_o/dat_o      : acknowledge, read data (0 outside the ack cycle)
interface bgr_startup_ctrl_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic        ack_o;
  logic [31:0] dat_o;

  modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  input  ack_o, dat_o);
  modport slave  (input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  output ack_o, dat_o);
endinterface

// File: rtl/bgr_sync2.sv
// Two-flop synchroniser for the asynchronous comparator flag.
//  clk_i : clock   rst_i : sync active-high reset (output clears to 0)
//  d_i   : async input   q_o : synchronised output, 2-cycle lag
module bgr_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ff_q <= '0;
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/bgr_startup_ctrl.sv
// Wishbone-programmable startup sequencer for the bandgap reference macro.
// Pulses porst_o for PORST_CYC cycles, waits SETTLE_CYC cycles, then samples the
// synchronised comparator flag and reports READY/FAIL/LOST via STATUS and irq_o.
//  wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//  wbs                : Wishbone slave bundle (2-cycle transfers, single-cycle ack)
//  bgr_ok_i           : asynchronous "vbg in range" flag
//  porst_o            : startup pulse to the macro's porst pin
//  irq_o              : level interrupt, IRQ_EN & (DONE|FAIL|LOST), registered
//  state_o            : current FSM state
module bgr_startup_ctrl
  import bgr_startup_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          CNT_W      = 16,
  parameter logic [CNT_W-1:0] DEF_PORST  = 16'd100,
  parameter logic [CNT_W-1:0] DEF_SETTLE = 16'd1000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  bgr_startup_ctrl_if.slave   wbs,
  input  logic                bgr_ok_i,
  output logic                porst_o,
  output logic                irq_o,
  output logic [2:0]          state_o
);

  bgr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] porst_cyc_q, settle_cyc_q, porst_load;
  logic             auto_q, irq_en_q;
  logic             done_q, fail_q, lost_q, irq_q;
  logic             ack_q;
  logic [31:0]      dat_q, rdat;
  logic             ok_s;
  logic             req, hit, wr, rd;
  logic [1:0]       off;
  logic             wr_ctrl, wr_status, wr_porst, wr_settle, start;
  logic             set_done, set_fail, set_lost;
  logic             unused_bits;

  bgr_sync2 u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (bgr_ok_i),
    .q_o   (ok_s)
  );

  // ---------------- bus decode ----------------
  // A held strobe is blocked while ack is high, so transfers are always 2 cycles.
  assign req = wbs.cyc_i & wbs.stb_i & ~ack_q;
  assign hit = (wbs.adr_i[31:4] == BASE_ADDR[31:4]);
  assign off = wbs.adr_i[3:2];
  assign wr  = req & wbs.we_i & hit;
  assign rd  = req & ~wbs.we_i & hit;

  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_status = wr && (off == OFF_STATUS);
  assign wr_porst  = wr && (off == OFF_PORST);
  assign wr_settle = wr && (off == OFF_SETTLE);
  assign start     = wr_ctrl & wbs.dat_i[CTRL_START];

  // Byte selects, the byte-lane address bits and unused data bits have no function.
  assign unused_bits = ^{wbs.sel_i, wbs.adr_i[1:0], wbs.dat_i};

  always_comb begin
    rdat = '0;
    case (off)
      OFF_CTRL: begin
        rdat[CTRL_AUTO]  = auto_q;
        rdat[CTRL_IRQEN] = irq_en_q;
      end
      OFF_STATUS: rdat = status_word(state_q, state_q == ST_READY, done_q, fail_q, lost_q);
      OFF_PORST:  rdat[CNT_W-1:0] = porst_cyc_q;
      OFF_SETTLE: rdat[CNT_W-1:0] = settle_cyc_q;
      default: ;
    endcase
  end

  // A zero PORST_CYC still gives a one-cycle pulse.
  assign porst_load = (porst_cyc_q == '0) ? CNT_W'(1) : porst_cyc_q;

  // ---------------- FSM ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    set_done = 1'b0;
    set_fail = 1'b0;
    set_lost = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_d = ST_PORST;
          cnt_d   = porst_load;
        end
      end
      ST_PORST: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_SETTLE;
          cnt_d   = settle_cyc_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        // 0 and 1 both leave after one cycle
        if (cnt_q <= CNT_W'(1)) state_d = ST_CHECK;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        if (ok_s) begin
          state_d  = ST_READY;
          set_done = 1'b1;
        end else begin
          state_d  = ST_FAIL;
          set_fail = 1'b1;
        end
      end
      ST_READY: begin
        // Loss of reference takes priority over a coincident START.
        if (!ok_s) begin
          set_lost = 1'b1;
          if (auto_q) begin
            state_d = ST_PORST;
            cnt_d   = porst_load;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (start) begin
          state_d = ST_PORST;
          cnt_d   = porst_load;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- register file / handshake ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      auto_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      porst_cyc_q  <= DEF_PORST;
      settle_cyc_q <= DEF_SETTLE;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      lost_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= rd ? rdat : '0;
      if (wr_ctrl) begin
        auto_q   <= wbs.dat_i[CTRL_AUTO];
        irq_en_q <= wbs.dat_i[CTRL_IRQEN];
      end
      if (wr_porst)  porst_cyc_q  <= wbs.dat_i[CNT_W-1:0];
      if (wr_settle) settle_cyc_q <= wbs.dat_i[CNT_W-1:0];
      // hardware set wins over a same-cycle write-1-to-clear
      done_q <= set_done | (done_q & ~(wr_status & wbs.dat_i[STAT_DONE]));
      fail_q <= set_fail | (fail_q & ~(wr_status & wbs.dat_i[STAT_FAIL]));
      lost_q <= set_lost | (lost_q & ~(wr_status & wbs.dat_i[STAT_LOST]));
      irq_q  <= irq_en_q & (done_q | fail_q | lost_q);
    end
  end

  assign wbs.ack_o = ack_q;
  assign wbs.dat_o = dat_q;
  assign porst_o   = (state_q == ST_PORST);
  assign irq_o     = irq_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
module tb_bgr_startup_ctrl;
  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_PORST  = 32'h3000_0008;
  localparam logic [31:0] A_SETTLE = 32'h3000_000C;
  localparam logic [31:0] A_OOR    = 32'h3000_0010;

  logic       clk = 1'b0;
  logic       rst;
  logic       bgr_ok;
  logic       porst, irq;
  logic [2:0] state;
  int         checks = 0;
  int         failures = 0;
  logic [31:0] rdv;

  bgr_startup_ctrl_if bus();

  bgr_startup_ctrl dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .bgr_ok_i (bgr_ok),
    .porst_o  (porst),
    .irq_o    (irq),
    .state_o  (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] r);
    bit got;
    got = 1'b0;
    r = '0;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = w; bus.adr_i = a; bus.dat_i = d;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (bus.ack_o) begin
        got = 1'b1;
        r = bus.dat_o;
      end
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    chk("wb_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, a, d, r);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, a, 32'd0, r);
    chk(nm, r, exp);
  endtask

  // polls state until it equals st; result reports success within the bound
  task automatic wait_state(input logic [2:0] st, input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      got = (state == st);
    end
  endtask

  initial begin
    int  n_por, rdy_at;
    bit  got, saw;

    rst = 1'b1; bgr_ok = 1'b1;
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.sel_i = 4'hF;
    bus.adr_i = '0; bus.dat_i = '0;

    // ---- reset ----
    tick(); tick();
    chk("rst_porst", {31'd0, porst}, 0);
    chk("rst_irq",   {31'd0, irq}, 0);
    chk("rst_ack",   {31'd0, bus.ack_o}, 0);
    chk("rst_dat",   bus.dat_o, 0);
    chk("rst_state", {29'd0, state}, 0);
    rst = 1'b0;
    tick();

    // ---- table-driven register access ----
    vecs[0]  = '{1'b0, A_PORST,  32'd0,          32'd100};
    vecs[1]  = '{1'b0, A_SETTLE, 32'd0,          32'd1000};
    vecs[2]  = '{1'b0, A_STATUS, 32'd0,          32'd0};
    vecs[3]  = '{1'b0, A_CTRL,   32'd0,          32'd0};
    vecs[4]  = '{1'b1, A_PORST,  32'h1234_0007,  32'd0};
    vecs[5]  = '{1'b0, A_PORST,  32'd0,          32'd7};
    vecs[6]  = '{1'b1, A_CTRL,   32'h6,          32'd0};
    vecs[7]  = '{1'b0, A_CTRL,   32'd0,          32'h6};
    vecs[8]  = '{1'b0, A_OOR,    32'd0,          32'd0};
    vecs[9]  = '{1'b1, A_OOR,    32'hFFFF,       32'd0};
    vecs[10] = '{1'b0, A_PORST,  32'd0,          32'd7};
    vecs[11] = '{1'b1, A_CTRL,   32'h0,          32'd0};
    vecs[12] = '{1'b0, 32'h4000_0008, 32'd0,     32'd0};
    for (int i = 0; i < 13; i++) begin
      wb(vecs[i].we, vecs[i].adr, vecs[i].dat, rdv);
      chk($sformatf("vec%0d", i), rdv, vecs[i].exp);
    end
    rdchk("ctrl_after_clear", A_CTRL, 32'd0);

    // ---- nominal: PORST=5 SETTLE=10 ----
    wr(A_PORST, 5); wr(A_SETTLE, 10);
    wr(A_CTRL, 32'h5);
    n_por = 0; rdy_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (porst) n_por++;
      if (state == 3'd4 && rdy_at < 0) rdy_at = i;
      tick();
    end
    chk("nom_porst_len", n_por, 5);
    chk("nom_ready_lat", rdy_at, 16);
    rdchk("nom_status", A_STATUS, 32'h1C);
    chk("nom_irq", {31'd0, irq}, 1);

    // ---- loss with AUTO_RESTART=1 ----
    wr(A_CTRL, 32'h6);
    wr(A_STATUS, 32'h70);
    rdchk("ar_status_clr", A_STATUS, 32'h0C);
    bgr_ok = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      tick();
      saw = porst;
    end
    chk("ar_repulse", {31'd0, saw}, 1);
    bgr_ok = 1'b1;
    wait_state(3'd4, 40, got);
    chk("ar_back_ready", {31'd0, got}, 1);
    rdchk("ar_status", A_STATUS, 32'h5C);

    // ---- loss with AUTO_RESTART=0 ----
    wr(A_CTRL, 32'h4);
    wr(A_STATUS, 32'h70);
    bgr_ok = 1'b0;
    got = 1'b0; saw = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      saw |= porst;
      got = (state == 3'd5);
    end
    chk("nar_to_fail", {31'd0, got}, 1);
    chk("nar_no_porst", {31'd0, saw}, 0);
    rdchk("nar_status", A_STATUS, 32'h45);
    chk("nar_irq", {31'd0, irq}, 1);

    // ---- W1C and irq lag ----
    wr(A_STATUS, 32'h70);
    chk("w1c_irq_lag", {31'd0, irq}, 1);
    tick();
    chk("w1c_irq_low", {31'd0, irq}, 0);

    // ---- check fails with bgr_ok low ----
    wr(A_CTRL, 32'h5);
    wait_state(3'd5, 40, got);
    chk("fail_reached", {31'd0, got}, 1);
    rdchk("fail_status", A_STATUS, 32'h25);
    chk("fail_irq", {31'd0, irq}, 1);
    wr(A_STATUS, 32'h20);
    tick();
    chk("fail_clr_irq", {31'd0, irq}, 0);
    rdchk("fail_clr_status", A_STATUS, 32'h05);

    // ---- W1C in the CHECK cycle: set wins ----
    wr(A_CTRL, 32'h5);
    wait_state(3'd3, 40, got);
    chk("chk_reached", {31'd0, got}, 1);
    wr(A_STATUS, 32'h20);
    rdchk("chk_set_wins", A_STATUS, 32'h25);

    // ---- zero counts ----
    wr(A_STATUS, 32'h70);
    wr(A_PORST, 0); wr(A_SETTLE, 0);
    bgr_ok = 1'b1;
    tick(); tick(); tick();
    wr(A_CTRL, 32'h1);
    n_por = 0; rdy_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (porst) n_por++;
      if (state == 3'd4 && rdy_at < 0) rdy_at = i;
      tick();
    end
    chk("zero_porst_len", n_por, 1);
    chk("zero_ready_lat", rdy_at, 3);

    // ---- START during SETTLE ignored ----
    wr(A_PORST, 5); wr(A_SETTLE, 10);
    wr(A_STATUS, 32'h70);
    wr(A_CTRL, 32'h1);
    wait_state(3'd2, 20, got);
    chk("settle_reached", {31'd0, got}, 1);
    wr(A_CTRL, 32'h1);
    n_por = 0;
    for (int i = 0; i < 30; i++) begin
      if (porst) n_por++;
      tick();
    end
    chk("settle_start_nopulse", n_por, 0);
    chk("settle_start_ready", {29'd0, state}, 4);
    rdchk("settle_start_status", A_STATUS, 32'h1C);

    // ---- back-to-back strobe ----
    tick();
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = A_CTRL;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("b2b_ack%0d", i), {31'd0, bus.ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    tick();

    // ---- reset during PORST ----
    wr(A_CTRL, 32'h1);
    tick();
    chk("rstmid_porst_pre", {31'd0, porst}, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_porst", {31'd0, porst}, 0);
    chk("rstmid_state", {29'd0, state}, 0);
    rst = 1'b0;
    tick();
    rdchk("rstmid_porst_cyc", A_PORST, 32'd100);
    rdchk("rstmid_status", A_STATUS, 32'd0);
    chk("rstmid_irq", {31'd0, irq}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
